dce_write_engine: RTL and testbench
===================================

Name: dce_write_engine

Overview:
- Data-cache-emulator (DCE) write responder: the memory end of the store-buffer-to-data-cache write interface.
- Accepts the committed store at the store-buffer head (address, data, valid), holds DCE_WriteBusy while a fixed-latency write is in flight, then pulses DCE_WriteDone so the store-address buffer can flush the matching tag.
- Owns the data word array. Also serves a single-cycle load read port that shares the array's one access slot.

Parameters:
- DEPTH_LOG2, 6: data array holds 2**DEPTH_LOG2 32-bit words.
- WRITE_LAT, 4: cycles DCE_WriteBusy stays high per store. Legal range 1..15.

Ports:
- clk, input, 1: single clock, rising edge.
- resetb, input, 1: asynchronous, active-high reset. Asserted = 1.
- SB_DataDmem, input, 32: store data at the store-buffer head.
- SB_AddrDmem, input, 32: store byte address at the store-buffer head.
- SB_DataValid, input, 1: store-buffer head holds a valid store.
- DCE_WriteBusy, output, 1: write in flight; no new store is taken.
- DCE_WriteDone, output, 1: one-cycle pulse when a store has committed to the array.
- Lsq_ReadEn, input, 1: load read request.
- Lsq_ReadAddr, input, 32: load byte address.
- DCE_ReadStall, output, 1: read not taken this cycle; requester holds the request.
- DCE_ReadData, output, 32: load data, registered.
- DCE_ReadValid, output, 1: DCE_ReadData is valid. One-cycle pulse.

Behaviour:
- Word index is addr[DEPTH_LOG2+1:2]. Bits [1:0] and the upper bits are ignored, so out-of-range addresses alias (wrap).
- Accept rule: a store is taken at the rising edge where SB_DataValid=1 and DCE_WriteBusy=0. This is the same condition on which the store buffer shifts. Address and data are captured into internal registers on that edge.
- FSM states:
  - IDLE: Busy=0, Done=0. Accept -> WRITE, lat_cnt <= WRITE_LAT-1.
  - WRITE: Busy=1, Done=0. lat_cnt decrements each cycle. When lat_cnt==0, the array is written at that edge -> DONE.
  - DONE: Busy=0, Done=1. If an accept happens this cycle -> WRITE (back-to-back). Otherwise -> IDLE.
- Timing, with accept at edge E0:
  - Busy is high for exactly WRITE_LAT cycles after E0.
  - The array is updated at edge E0+WRITE_LAT.
  - Done pulses in the following cycle.
  - Back-to-back throughput is one store per WRITE_LAT+1 cycles.
- Done never overlaps Busy. Done is never asserted for two consecutive cycles.
- SB_AddrDmem and SB_DataDmem are ignored while Busy=1. Changes to them during WRITE have no effect.
- lat_cnt is 4 bits. It never underflows; it is reloaded on every accept.
- Read port:
  - The array has one access slot per cycle. A write commit (WRITE with lat_cnt==0) owns that slot.
  - DCE_ReadStall = Lsq_ReadEn && (state==WRITE && lat_cnt==0). It is combinational.
  - A taken read registers array[idx] and pulses DCE_ReadValid in the next cycle.
  - A stalled read produces no ReadValid. The requester holds ReadEn and ReadAddr, and the read is taken next cycle.
  - A read in the cycle after a commit returns the new data. There is no forwarding from the in-flight capture register, so a read before commit returns old data.
- Reset (asynchronous, any time, including mid-WRITE):
  - state=IDLE, lat_cnt=0.
  - DCE_WriteBusy=0, DCE_WriteDone=0, DCE_ReadValid=0, DCE_ReadData=0.
  - An in-flight store that has not reached its commit edge is dropped; the array is left unchanged.
  - The array itself is not reset.
  - After reset is released, a held SB_DataValid is accepted on the first edge.

Decomposition:
- Package dce_pkg holds:
  - the state enum {IDLE, WRITE, DONE} (2-bit encoding);
  - the WORD_BYTES=4 constant;
  - the LAT_CNT_W=4 constant;
  - the word-index extraction function.
- One sub-module, dce_data_ram: single-port synchronous RAM with write enable, index, wdata, and registered rdata.
- The top level holds the FSM, the capture registers and the read/write arbitration.

Test Plan:
- Reset, then Valid=1, Addr=0x10, Data=0xDEADBEEF -> Busy high for 4 cycles, Done pulses once in cycle 5, a later read of 0x10 returns 0xDEADBEEF with ReadValid one cycle after ReadEn.
- Valid held high with three stores: 0x0/0x11, 0x4/0x22, 0x8/0x33 -> accepts 5 cycles apart, 3 Done pulses, Busy and Done never both high, array contents match.
- Read of 0x4 issued exactly in the commit cycle of a store to 0x4 -> ReadStall=1 that cycle, the retried read the next cycle returns the new data.
- Store to 0x104 with DEPTH_LOG2=6 -> aliases to index 1; a read of 0x4 returns the stored value.
- resetb asserted in cycle 2 of WRITE for a store to 0x20 (old value 0x5) -> Busy and Done drop immediately, no Done pulse, read of 0x20 returns 0x5.
- WRITE_LAT=1 with back-to-back Valid -> Busy 1 cycle, Done 1 cycle, alternating pattern; data changes on SB_DataDmem during Busy are ignored.

Source files
------------

// File: rtl/dce_pkg.sv
// dce_pkg: shared types and helpers for the data-cache-emulator write engine.
//   dceState_t  - write FSM state encoding (IDLE / WRITE / DONE)
//   WORD_BYTES  - bytes per data-array word
//   LAT_CNT_W   - width of the write-latency down-counter
//   wordIndex() - byte address to word address (caller keeps the low bits it needs)
package dce_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } dceState_t;

  localparam int WORD_BYTES = 4;
  localparam int LAT_CNT_W  = 4;

  // Drops the byte-offset bits; the caller slices off the array index bits,
  // so anything above the array depth aliases back into range.
  function automatic logic [31:0] wordIndex(input logic [31:0] byteAddr);
    return byteAddr >> $clog2(WORD_BYTES);
  endfunction

endpackage

// File: rtl/dce_data_ram.sv
// dce_data_ram: single-port synchronous data array with a registered read port.
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-high reset (clears only the read register)
//   we_i     - write enable; writes wdata_i to mem[idx_i]
//   re_i     - read enable; registers mem[idx_i] into rdata_o
//   idx_i    - word index shared by the read and the write
//   wdata_i  - write data
//   rdata_o  - registered read data, holds its value when re_i is low
module dce_data_ram #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [WIDTH-1:0] rdata_q;

  // The array contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dce_write_engine.sv
// dce_write_engine: memory end of the store-buffer to data-cache write path.
// Takes the committed store at the store-buffer head, keeps DCE_WriteBusy high
// for WRITE_LAT cycles, commits the word to the array and pulses DCE_WriteDone.
// A single-cycle load port shares the array's one access slot; a write commit
// wins that slot and the load is stalled for the cycle.
//   clk            - clock, rising edge
//   resetb         - asynchronous active-high reset
//   SB_DataDmem    - store data at the store-buffer head
//   SB_AddrDmem    - store byte address at the store-buffer head
//   SB_DataValid   - store-buffer head holds a valid store
//   DCE_WriteBusy  - write in flight, no new store taken
//   DCE_WriteDone  - one-cycle pulse after the store has reached the array
//   Lsq_ReadEn     - load read request
//   Lsq_ReadAddr   - load byte address
//   DCE_ReadStall  - load not taken this cycle (combinational)
//   DCE_ReadData   - registered load data
//   DCE_ReadValid  - one-cycle pulse, DCE_ReadData valid
// WRITE_LAT must lie in 1..15 to fit the 4-bit latency counter.
module dce_write_engine
  import dce_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int WRITE_LAT  = 4
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [31:0] SB_DataDmem,
  input  logic [31:0] SB_AddrDmem,
  input  logic        SB_DataValid,
  output logic        DCE_WriteBusy,
  output logic        DCE_WriteDone,
  input  logic        Lsq_ReadEn,
  input  logic [31:0] Lsq_ReadAddr,
  output logic        DCE_ReadStall,
  output logic [31:0] DCE_ReadData,
  output logic        DCE_ReadValid
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(WRITE_LAT - 1);

  dceState_t             state_q, state_d;
  logic [LAT_CNT_W-1:0]  latCnt_q, latCnt_d;
  logic [DEPTH_LOG2-1:0] wrIdx_q;
  logic [31:0]           wrData_q;
  logic                  readValid_q;

  logic [31:0]           sbWord, rdWord;
  logic [DEPTH_LOG2-1:0] sbIdx, rdIdx, ramIdx;
  logic                  accept, commit, readTake;
  logic                  busy, done;
  logic                  unusedAddrBits;

  assign sbWord = wordIndex(SB_AddrDmem);
  assign rdWord = wordIndex(Lsq_ReadAddr);
  assign sbIdx  = sbWord[DEPTH_LOG2-1:0];
  assign rdIdx  = rdWord[DEPTH_LOG2-1:0];

  // Upper address bits are intentionally discarded so addresses wrap.
  assign unusedAddrBits = ^{sbWord[31:DEPTH_LOG2], rdWord[31:DEPTH_LOG2]};

  // Same condition the store buffer uses to shift, so both sides agree on
  // exactly which edge consumed the head entry.
  assign accept   = SB_DataValid && (state_q != WRITE);
  // The last WRITE cycle owns the array slot; a load in that cycle waits.
  assign commit   = (state_q == WRITE) && (latCnt_q == '0);
  assign readTake = Lsq_ReadEn && !commit;

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      state_q  <= IDLE;
      latCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      latCnt_q <= latCnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    latCnt_d = latCnt_q;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = WRITE;
          latCnt_d = LAT_LOAD;
        end
      end
      WRITE: begin
        busy = 1'b1;
        if (latCnt_q == '0) begin
          state_d = DONE;
        end else begin
          latCnt_d = latCnt_q - 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        // Back-to-back store: the buffer's next head is taken while Done pulses.
        if (accept) begin
          state_d  = WRITE;
          latCnt_d = LAT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture address and data on accept; the head may change freely afterwards.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      wrIdx_q  <= '0;
      wrData_q <= '0;
    end else if (accept) begin
      wrIdx_q  <= sbIdx;
      wrData_q <= SB_DataDmem;
    end
  end

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      readValid_q <= 1'b0;
    end else begin
      readValid_q <= readTake;
    end
  end

  assign ramIdx = commit ? wrIdx_q : rdIdx;

  dce_data_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (32)
  ) u_ram (
    .clk_i  (clk),
    .rst_i  (resetb),
    .we_i   (commit),
    .re_i   (readTake),
    .idx_i  (ramIdx),
    .wdata_i(wrData_q),
    .rdata_o(DCE_ReadData)
  );

  assign DCE_WriteBusy = busy;
  assign DCE_WriteDone = done;
  assign DCE_ReadStall = Lsq_ReadEn && commit;
  assign DCE_ReadValid = readValid_q;

endmodule

// File: tb/tb_dce_write_engine.sv
// tb_dce_write_engine: drives two engines (WRITE_LAT 4 and 1) with identical
// stimulus and compares every cycle against a reference model that tracks
// "cycles since accept" per engine plus a plain word array.
module tb_dce_write_engine;

  localparam int DEPTH_LOG2 = 6;
  localparam int NWORDS     = 64;
  localparam int LAT0       = 4;
  localparam int LAT1       = 1;

  logic        clk, resetb;
  logic [31:0] sbData, sbAddr, rdAddr;
  logic        sbValid, rdEn;
  logic [1:0]  busyO, doneO, stallO, rdValidO;
  logic [31:0] rdData0, rdData1;

  dce_write_engine #(.DEPTH_LOG2(DEPTH_LOG2), .WRITE_LAT(LAT0)) dut0 (
    .clk(clk), .resetb(resetb),
    .SB_DataDmem(sbData), .SB_AddrDmem(sbAddr), .SB_DataValid(sbValid),
    .DCE_WriteBusy(busyO[0]), .DCE_WriteDone(doneO[0]),
    .Lsq_ReadEn(rdEn), .Lsq_ReadAddr(rdAddr),
    .DCE_ReadStall(stallO[0]), .DCE_ReadData(rdData0), .DCE_ReadValid(rdValidO[0])
  );

  dce_write_engine #(.DEPTH_LOG2(DEPTH_LOG2), .WRITE_LAT(LAT1)) dut1 (
    .clk(clk), .resetb(resetb),
    .SB_DataDmem(sbData), .SB_AddrDmem(sbAddr), .SB_DataValid(sbValid),
    .DCE_WriteBusy(busyO[1]), .DCE_WriteDone(doneO[1]),
    .Lsq_ReadEn(rdEn), .Lsq_ReadAddr(rdAddr),
    .DCE_ReadStall(stallO[1]), .DCE_ReadData(rdData1), .DCE_ReadValid(rdValidO[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks, failures;

  // Model: k = cycles since the accept edge (-1 when no store in flight).
  int          k        [2];
  logic [31:0] mMem     [2][NWORDS];
  int          pIdx     [2];
  logic [31:0] pData    [2];
  logic [31:0] mRdData  [2];
  logic        mRdValid [2];
  logic        mAccepted[2];
  logic        mReadTaken[2];

  int   edgeCount, busyCnt0, doneCnt0;
  logic lastStall0;

  function automatic int lat(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int wordOf(input logic [31:0] a);
    return int'((a / 32'd4) % NWORDS);
  endfunction

  function automatic logic [31:0] obsRdData(input int i);
    return (i == 0) ? rdData0 : rdData1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelEdge();
    for (int i = 0; i < 2; i++) begin
      int   L;
      logic commitNow, busyPre;
      L         = lat(i);
      commitNow = (k[i] == L);
      busyPre   = (k[i] >= 1) && (k[i] <= L);
      if (commitNow) mMem[i][pIdx[i]] = pData[i];
      mReadTaken[i] = rdEn && !commitNow;
      if (mReadTaken[i]) mRdData[i] = mMem[i][wordOf(rdAddr)];
      mRdValid[i]  = mReadTaken[i];
      mAccepted[i] = sbValid && !busyPre;
      if (mAccepted[i]) begin
        pIdx[i]  = wordOf(sbAddr);
        pData[i] = sbData;
        k[i]     = 1;
      end else if (busyPre) begin
        k[i] = k[i] + 1;
      end else begin
        k[i] = -1;
      end
    end
  endtask

  task automatic checkPost();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("busy%0d", i), busyO[i], (k[i] >= 1) && (k[i] <= lat(i)));
      checkOutput($sformatf("done%0d", i), doneO[i], k[i] == lat(i) + 1);
      checkOutput($sformatf("overlap%0d", i), busyO[i] & doneO[i], 0);
      checkOutput($sformatf("rdValid%0d", i), rdValidO[i], mRdValid[i]);
      checkOutput($sformatf("rdData%0d", i), obsRdData(i), mRdData[i]);
    end
  endtask

  // One clock: drive inputs, check the combinational stall, take the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                               input logic re, input logic [31:0] ra);
    sbValid = v; sbAddr = a; sbData = d; rdEn = re; rdAddr = ra;
    #1;
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("stall%0d", i), stallO[i], rdEn && (k[i] == lat(i)));
    lastStall0 = stallO[0];
    @(posedge clk);
    modelEdge();
    edgeCount++;
    #1;
    checkPost();
    if (busyO[0]) busyCnt0++;
    if (doneO[0]) doneCnt0++;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, sbAddr, $urandom, 1'b0, 32'h0);
  endtask

  // Store-buffer head behaviour: hold the entry until engine 0 takes it.
  task automatic pushStore(input logic [31:0] a, input logic [31:0] d, output int accEdge);
    logic got;
    got = 1'b0;
    accEdge = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      applyStimulus(1'b1, a, d, 1'b0, 32'h0);
      if (mAccepted[0]) begin
        got = 1'b1;
        accEdge = edgeCount;
      end
    end
    checkOutput("pushAccepted", got, 1'b1);
  endtask

  task automatic readRequest(input logic [31:0] a, output logic [31:0] data);
    logic got;
    got = 1'b0;
    data = 32'h0;
    for (int n = 0; n < 10 && !got; n++) begin
      applyStimulus(1'b0, sbAddr, sbData, 1'b1, a);
      if (mReadTaken[0]) begin
        got = 1'b1;
        checkOutput("readValidNextCycle", rdValidO[0], 1'b1);
        data = rdData0;
      end
    end
    checkOutput("readTaken", got, 1'b1);
  endtask

  task automatic doReset();
    resetb = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rstBusy%0d", i), busyO[i], 1'b0);
      checkOutput($sformatf("rstDone%0d", i), doneO[i], 1'b0);
      checkOutput($sformatf("rstRdValid%0d", i), rdValidO[i], 1'b0);
      checkOutput($sformatf("rstRdData%0d", i), obsRdData(i), 32'h0);
      k[i] = -1; mRdValid[i] = 1'b0; mRdData[i] = 32'h0;
    end
    @(posedge clk);
    #1;
    resetb = 1'b0;
  endtask

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e1, e2, e3;
    logic [31:0] rd, lastAcc1, d;
    checks = 0; failures = 0; edgeCount = 0; busyCnt0 = 0; doneCnt0 = 0;
    sbValid = 1'b0; sbAddr = '0; sbData = '0; rdEn = 1'b0; rdAddr = '0;
    lastAcc1 = '0;
    for (int i = 0; i < 2; i++) begin
      k[i] = -1; mRdData[i] = 32'h0; mRdValid[i] = 1'b0;
      mAccepted[i] = 1'b0; mReadTaken[i] = 1'b0; pIdx[i] = 0; pData[i] = '0;
      for (int j = 0; j < NWORDS; j++) mMem[i][j] = 'x;
    end
    resetb = 1'b1;
    @(posedge clk);
    #1;
    doReset();

    // Single store, latency and readback.
    busyCnt0 = 0; doneCnt0 = 0;
    pushStore(32'h10, 32'hDEADBEEF, e1);
    idle(6);
    checkOutput("t1BusyCycles", busyCnt0, LAT0);
    checkOutput("t1DonePulses", doneCnt0, 1);
    readRequest(32'h10, rd);
    checkOutput("t1ReadBack", rd, 32'hDEADBEEF);

    // Three back-to-back stores with Valid held.
    doneCnt0 = 0;
    pushStore(32'h0, 32'h11, e1);
    pushStore(32'h4, 32'h22, e2);
    pushStore(32'h8, 32'h33, e3);
    idle(6);
    checkOutput("t2Spacing12", e2 - e1, LAT0 + 1);
    checkOutput("t2Spacing23", e3 - e2, LAT0 + 1);
    checkOutput("t2DonePulses", doneCnt0, 3);
    readRequest(32'h0, rd); checkOutput("t2Read0", rd, 32'h11);
    readRequest(32'h4, rd); checkOutput("t2Read4", rd, 32'h22);
    readRequest(32'h8, rd); checkOutput("t2Read8", rd, 32'h33);

    // Read colliding with the commit cycle is stalled, then returns new data.
    pushStore(32'h4, 32'hA5A50004, e1);
    idle(LAT0 - 1);
    applyStimulus(1'b0, sbAddr, sbData, 1'b1, 32'h4);
    checkOutput("t3StallAtCommit", lastStall0, 1'b1);
    checkOutput("t3NoValidWhenStalled", rdValidO[0], 1'b0);
    applyStimulus(1'b0, sbAddr, sbData, 1'b1, 32'h4);
    checkOutput("t3RetryNoStall", lastStall0, 1'b0);
    checkOutput("t3RetryValid", rdValidO[0], 1'b1);
    checkOutput("t3RetryData", rdData0, 32'hA5A50004);
    idle(2);

    // Address aliasing.
    pushStore(32'h104, 32'hCAFE0104, e1);
    idle(6);
    readRequest(32'h4, rd);
    checkOutput("t4Alias", rd, 32'hCAFE0104);

    // Reset in the second WRITE cycle drops the in-flight store.
    pushStore(32'h20, 32'h5, e1);
    idle(6);
    pushStore(32'h20, 32'h99999999, e1);
    idle(1);
    doReset();
    doneCnt0 = 0;
    idle(6);
    checkOutput("t5NoDoneAfterReset", doneCnt0, 0);
    readRequest(32'h20, rd);
    checkOutput("t5OldValueKept", rd, 32'h5);

    // WRITE_LAT=1 engine: alternating Busy/Done, data changes while busy ignored.
    idle(6);
    for (int j = 0; j < 8; j++) begin
      d = $urandom;
      applyStimulus(1'b1, 32'h40, d, 1'b0, 32'h0);
      if (j % 2 == 0) lastAcc1 = d;
      checkOutput($sformatf("t6Busy_%0d", j), busyO[1], (j % 2) == 0);
      checkOutput($sformatf("t6Done_%0d", j), doneO[1], (j % 2) == 1);
    end
    idle(6);
    readRequest(32'h40, rd);
    checkOutput("t6Lat1Data", rdData1, lastAcc1);

    // Fill the array, then random traffic checked by the model every cycle.
    for (int i = 0; i < NWORDS; i++) pushStore(32'(i * 4), $urandom, e1);
    idle(6);
    for (int n = 0; n < 1500; n++) begin
      applyStimulus(($urandom % 3) != 0, $urandom, $urandom, ($urandom % 2) == 1, $urandom);
      if (n == 750) doReset();
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
